// File: rtl/btb_pkg.sv
// Shared constants for the branch target buffer: 2-bit counter states and field width helpers.
package btb_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [1:0] CTR_INIT_DEF = WT;

    function automatic int unsigned tag_width(input int unsigned aw, input int unsigned idx_bits);
        return aw - idx_bits;
    endfunction

endpackage

// File: rtl/btb_sat_ctr.sv
// Combinational next state of a 2-bit saturating branch predictor counter.
module btb_sat_ctr
    import btb_pkg::*;
(
    input  logic [1:0] ctr_in,
    input  logic       taken,
    output logic [1:0] ctr_out
);

    always_comb begin
        ctr_out = ctr_in;
        if (taken) begin
            if (ctr_in != ST) ctr_out = ctr_in + 2'd1;
        end else begin
            if (ctr_in != SNT) ctr_out = ctr_in - 2'd1;
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit predictors, execute-stage target adder and mispredict detection.
// Optional statistics counters are compiled in when BTB_STATS_EN is defined.
module branch_target_buffer
    import btb_pkg::*;
#(
    parameter int unsigned AW       = 32,
    parameter int unsigned IDX_BITS = 4,
    parameter logic [1:0]  CTR_INIT = CTR_INIT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] PCF,
    output logic          PredTakenF,
    output logic [AW-1:0] PredTargetF,
    input  logic          BranchE,
    input  logic          TakenE,
    input  logic          StallE,
    input  logic [AW-1:0] simmE,
    input  logic [AW-1:0] PCp1E,
    input  logic          PredTakenE,
    input  logic [AW-1:0] PredTargetE,
    output logic [AW-1:0] PCBranchE,
    output logic          MispredictE,
    output logic [AW-1:0] CorrectPCE
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]   LookupCntO,
    output logic [31:0]   HitCntO,
    output logic [31:0]   MispredCntO
`endif
);

    localparam int unsigned DEPTH    = 1 << IDX_BITS;
    localparam int unsigned TAG_BITS = tag_width(AW, IDX_BITS);

    logic                valid_q  [DEPTH];
    logic [TAG_BITS-1:0] tag_q    [DEPTH];
    logic [AW-1:0]       target_q [DEPTH];
    logic [1:0]          ctr_q    [DEPTH];

    logic [IDX_BITS-1:0] idx_f, idx_e;
    logic [TAG_BITS-1:0] tag_f, tag_e;
    logic [AW-1:0]       pc_e;
    logic                hit_f, hit_e, upd_en;
    logic [1:0]          ctr_nxt;

    // Fetch lookup reads the stored table directly, so same-cycle updates are not visible.
    assign idx_f       = PCF[IDX_BITS-1:0];
    assign tag_f       = PCF[AW-1:IDX_BITS];
    assign hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign PredTakenF  = hit_f && ctr_q[idx_f][1];
    assign PredTargetF = PredTakenF ? target_q[idx_f] : '0;

    assign PCBranchE   = PCp1E + simmE;
    assign CorrectPCE  = TakenE ? PCBranchE : PCp1E;
    assign upd_en      = BranchE && !StallE;
    assign MispredictE = upd_en && ((PredTakenE != TakenE) ||
                                    (TakenE && (PredTargetE != PCBranchE)));

    assign pc_e  = PCp1E - {{(AW-1){1'b0}}, 1'b1};
    assign idx_e = pc_e[IDX_BITS-1:0];
    assign tag_e = pc_e[AW-1:IDX_BITS];
    assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

    btb_sat_ctr u_sat_ctr (
        .ctr_in  (ctr_q[idx_e]),
        .taken   (TakenE),
        .ctr_out (ctr_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_INIT;
            end
        end else if (upd_en) begin
            if (hit_e) begin
                ctr_q[idx_e] <= ctr_nxt;
                if (TakenE) target_q[idx_e] <= PCBranchE;
            end else if (TakenE) begin
                // Allocation evicts whatever aliases at this index.
                valid_q[idx_e]  <= 1'b1;
                tag_q[idx_e]    <= tag_e;
                target_q[idx_e] <= PCBranchE;
                ctr_q[idx_e]    <= CTR_INIT;
            end
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] lookup_cnt_q, hit_cnt_q, mispred_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lookup_cnt_q  <= '0;
            hit_cnt_q     <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (lookup_cnt_q != '1)              lookup_cnt_q  <= lookup_cnt_q + 32'd1;
            if (hit_f && hit_cnt_q != '1)        hit_cnt_q     <= hit_cnt_q + 32'd1;
            if (MispredictE && mispred_cnt_q != '1) mispred_cnt_q <= mispred_cnt_q + 32'd1;
        end
    end

    assign LookupCntO  = lookup_cnt_q;
    assign HitCntO     = hit_cnt_q;
    assign MispredCntO = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: directed steps queue expectations, a monitor checks them.
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic        BranchE, TakenE, StallE, PredTakenE;
    logic [31:0] simmE, PCp1E, PredTargetE;
    logic [31:0] PCBranchE, CorrectPCE;
    logic        MispredictE;
`ifdef BTB_STATS_EN
    logic [31:0] LookupCntO, HitCntO, MispredCntO;
`endif

    branch_target_buffer dut (
        .clk         (clk),
        .reset       (reset),
        .PCF         (PCF),
        .PredTakenF  (PredTakenF),
        .PredTargetF (PredTargetF),
        .BranchE     (BranchE),
        .TakenE      (TakenE),
        .StallE      (StallE),
        .simmE       (simmE),
        .PCp1E       (PCp1E),
        .PredTakenE  (PredTakenE),
        .PredTargetE (PredTargetE),
        .PCBranchE   (PCBranchE),
        .MispredictE (MispredictE),
        .CorrectPCE  (CorrectPCE)
`ifdef BTB_STATS_EN
        ,
        .LookupCntO  (LookupCntO),
        .HitCntO     (HitCntO),
        .MispredCntO (MispredCntO)
`endif
    );

    always #5 clk = ~clk;

    typedef enum logic [2:0] {KPredTk, KPredTgt, KBrTgt, KMisp, KCorr, KStat} kind_e;
    typedef struct {
        kind_e       kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   done   = 1'b0;

    task automatic expect_val(input kind_e k, input logic [31:0] v, input string n);
        exp_t e;
        e.kind = k;
        e.val  = v;
        e.name = n;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs just after the rising edge.
    task automatic drive(input logic rst, input logic [31:0] pcf, input logic br, input logic tk,
                         input logic st, input logic [31:0] pcp1, input logic [31:0] simm,
                         input logic ptk, input logic [31:0] ptgt);
        reset       = rst;
        PCF         = pcf;
        BranchE     = br;
        TakenE      = tk;
        StallE      = st;
        PCp1E       = pcp1;
        simmE       = simm;
        PredTakenE  = ptk;
        PredTargetE = ptgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pred(input logic tk, input logic [31:0] tgt, input string n);
        expect_val(KPredTk, {31'd0, tk}, n);
        expect_val(KPredTgt, tgt, n);
    endtask

    task automatic exe(input logic [31:0] brt, input logic misp, input logic [31:0] corr,
                       input string n);
        expect_val(KBrTgt, brt, n);
        expect_val(KMisp, {31'd0, misp}, n);
        expect_val(KCorr, corr, n);
    endtask

    // Monitor: outputs are combinational and settle before the falling edge.
    always @(negedge clk) begin
        logic [31:0] act;
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            case (e.kind)
                KPredTk:  act = {31'd0, PredTakenF};
                KPredTgt: act = PredTargetF;
                KBrTgt:   act = PCBranchE;
                KMisp:    act = {31'd0, MispredictE};
                KCorr:    act = CorrectPCE;
`ifdef BTB_STATS_EN
                KStat:    act = LookupCntO | HitCntO | MispredCntO;
`endif
                default:  act = 32'hDEAD_BEEF;
            endcase
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s kind=%0d got=0x%08h want=0x%08h", e.name, e.kind, act, e.val);
            end
        end
    end

    initial begin
        drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        tick();
        tick();

        drive(1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        pred(1'b0, 32'h0, "reset_lookup");
`ifdef BTB_STATS_EN
        expect_val(KStat, 32'h0, "stats_after_reset");
`endif
        tick();

        // First taken branch allocates; fetch still sees the old contents this cycle.
        drive(1'b0, 32'h40, 1'b1, 1'b1, 1'b0, 32'h41, 32'h10, 1'b0, 32'h0);
        exe(32'h51, 1'b1, 32'h51, "alloc_exe");
        pred(1'b0, 32'h0, "alloc_rbw");
        tick();

        drive(1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        pred(1'b1, 32'h51, "alloc_hit");
        tick();

        // ctr 10 -> 01 -> 00, then taken 01, 10, 11, 11, then not-taken 10.
        drive(1'b0, 32'h40, 1'b1, 1'b0, 1'b0, 32'h41, 32'h10, 1'b1, 32'h51);
        exe(32'h51, 1'b1, 32'h41, "nt1_exe");
        pred(1'b1, 32'h51, "nt1_pred");
        tick();
        drive(1'b0, 32'h40, 1'b1, 1'b0, 1'b0, 32'h41, 32'h10, 1'b0, 32'h0);
        exe(32'h51, 1'b0, 32'h41, "nt2_exe");
        pred(1'b0, 32'h0, "ctr01_pred");
        tick();
        drive(1'b0, 32'h40, 1'b1, 1'b1, 1'b0, 32'h41, 32'h10, 1'b0, 32'h0);
        exe(32'h51, 1'b1, 32'h51, "t1_exe");
        pred(1'b0, 32'h0, "ctr00_pred");
        tick();
        drive(1'b0, 32'h40, 1'b1, 1'b1, 1'b0, 32'h41, 32'h10, 1'b0, 32'h0);
        pred(1'b0, 32'h0, "ctr01b_pred");
        tick();
        drive(1'b0, 32'h40, 1'b1, 1'b1, 1'b0, 32'h41, 32'h10, 1'b1, 32'h51);
        exe(32'h51, 1'b0, 32'h51, "t3_exe_correct");
        pred(1'b1, 32'h51, "ctr10_pred");
        tick();
        drive(1'b0, 32'h40, 1'b1, 1'b1, 1'b0, 32'h41, 32'h10, 1'b1, 32'h50);
        exe(32'h51, 1'b1, 32'h51, "t4_exe_badtgt");
        pred(1'b1, 32'h51, "ctr11_pred");
        tick();
        drive(1'b0, 32'h40, 1'b1, 1'b0, 1'b0, 32'h41, 32'h10, 1'b1, 32'h51);
        pred(1'b1, 32'h51, "ctr11_sat_pred");
        tick();
        drive(1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        pred(1'b1, 32'h51, "ctr10_after_sat");
        tick();

        // Alias at index 0: 0x50 evicts 0x40.
        drive(1'b0, 32'h50, 1'b1, 1'b1, 1'b0, 32'h51, 32'h5, 1'b0, 32'h0);
        exe(32'h56, 1'b1, 32'h56, "alias_exe");
        pred(1'b0, 32'h0, "alias_pre");
        tick();
        drive(1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        pred(1'b0, 32'h0, "alias_evicted");
        tick();
        drive(1'b0, 32'h50, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        pred(1'b1, 32'h56, "alias_new_hit");
        tick();

        // Wrap: PCE = 0xFFFFFFFF, index 0xF, tag 0x0FFFFFFF.
        drive(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFE, 1'b0, 32'h0);
        exe(32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFE, "wrap_exe");
        pred(1'b0, 32'h0, "wrap_pre");
        tick();
        drive(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        pred(1'b1, 32'hFFFF_FFFE, "wrap_hit");
        tick();
        drive(1'b0, 32'h0000_000F, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        pred(1'b0, 32'h0, "wrap_tag_miss");
        tick();

        // Stalled update is ignored.
        drive(1'b0, 32'h60, 1'b1, 1'b1, 1'b1, 32'h61, 32'h3, 1'b0, 32'h0);
        exe(32'h64, 1'b0, 32'h64, "stall_exe");
        tick();
        drive(1'b0, 32'h60, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        pred(1'b0, 32'h0, "stall_no_write");
        tick();

        // Not-taken miss does not allocate.
        drive(1'b0, 32'h80, 1'b1, 1'b0, 1'b0, 32'h81, 32'h7, 1'b0, 32'h0);
        exe(32'h88, 1'b0, 32'h81, "ntmiss_exe");
        tick();
        drive(1'b0, 32'h80, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        pred(1'b0, 32'h0, "ntmiss_no_write");
        tick();

        // Reset with a concurrent update: table cleared and the update dropped.
        drive(1'b1, 32'h50, 1'b1, 1'b1, 1'b0, 32'h71, 32'h1, 1'b0, 32'h0);
        tick();
        drive(1'b0, 32'h70, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        pred(1'b0, 32'h0, "reset_drop_update");
`ifdef BTB_STATS_EN
        expect_val(KStat, 32'h0, "stats_cleared");
`endif
        tick();
        drive(1'b0, 32'h50, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        pred(1'b0, 32'h0, "reset_cleared_50");
        tick();
        drive(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        pred(1'b0, 32'h0, "reset_cleared_wrap");
        tick();

        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain left=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
